// File: rtl/sterownik_rejestru_przesuwajacego_pkg.sv
// sterownik_rp_pkg
// Shared types and constants for the shift-register command sequencer.
//   op_t    : command opcodes carried on the command channel
//   stan_t  : sequencer FSM states
//   TRYB_*  : S1S0 mode codes of the 4-bit universal shift register
//   tryb_stanu() : S1S0 value that belongs to a given state/opcode pair
package sterownik_rp_pkg;

  typedef enum logic [1:0] {
    OP_LOAD     = 2'b00,
    OP_SHR      = 2'b01,
    OP_SHL      = 2'b10,
    OP_LOAD_SHR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    FIN   = 2'b11
  } stan_t;

  localparam logic [1:0] TRYB_WSTRZYMAJ = 2'b00;
  localparam logic [1:0] TRYB_PRAWO     = 2'b01;
  localparam logic [1:0] TRYB_LEWO      = 2'b10;
  localparam logic [1:0] TRYB_WPIS      = 2'b11;

  // Mode lines are a pure function of the state being entered; only SHIFT
  // looks at the opcode to pick the direction.
  function automatic logic [1:0] tryb_stanu(input stan_t stan, input op_t op);
    logic [1:0] tryb;
    case (stan)
      LOAD:    tryb = TRYB_WPIS;
      SHIFT:   tryb = (op == OP_SHL) ? TRYB_LEWO : TRYB_PRAWO;
      default: tryb = TRYB_WSTRZYMAJ;
    endcase
    return tryb;
  endfunction

endpackage

// File: rtl/sterownik_rejestru_przesuwajacego_if.sv
// sterownik_rejestru_przesuwajacego_if
// Command channel into the shift-register sequencer (valid/ready handshake).
//   cmd_valid : command valid (master)
//   cmd_ready : sequencer can accept a command (slave)
//   cmd_op    : opcode (op_t)
//   cmd_data  : parallel-load value, WIDTH bits
//   cmd_n     : shift count, CNT_W bits
// Modports: master = control logic issuing commands, slave = sequencer.
interface sterownik_rejestru_przesuwajacego_if
  import sterownik_rp_pkg::*;
  #(parameter int WIDTH = 4,
    parameter int CNT_W = 3);

  logic             cmd_valid;
  logic             cmd_ready;
  op_t              cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_n;

  modport master (output cmd_valid, output cmd_op, output cmd_data, output cmd_n,
                  input  cmd_ready);

  modport slave  (input  cmd_valid, input  cmd_op, input  cmd_data, input  cmd_n,
                  output cmd_ready);

endinterface

// File: rtl/sterownik_rejestru_przesuwajacego_bufor_polecen.sv
// bufor_polecen
// One-entry command holding register between the command channel and the FSM.
// With ENABLE=1 it is a fall-through skid entry: an empty buffer forwards the
// incoming command straight to the FSM, and only parks it when the FSM is not
// taking commands. With ENABLE=0 the entry never fills, so it degenerates to a
// wire and in_ready follows out_ready.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : upstream handshake, in_op/in_data/in_n payload
//   out_valid/out_ready   : downstream (FSM) handshake, out_op/out_data/out_n payload
module bufor_polecen
  import sterownik_rp_pkg::*;
  #(parameter int WIDTH  = 4,
    parameter int CNT_W  = 3,
    parameter bit ENABLE = 1'b0)
  (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_t              in_op,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_n,
    output logic             out_valid,
    input  logic             out_ready,
    output op_t              out_op,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_n
  );

  logic             full;
  op_t              op_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] n_q;
  logic             capture;

  // Park a command only when it arrives while the FSM is busy.
  assign capture = ENABLE && in_valid && !full && !out_ready;

  // Holding register: fills on capture, drains once the FSM takes the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      full   <= 1'b0;
      op_q   <= OP_LOAD;
      data_q <= '0;
      n_q    <= '0;
    end else if (capture) begin
      full   <= 1'b1;
      op_q   <= in_op;
      data_q <= in_data;
      n_q    <= in_n;
    end else if (full && out_ready) begin
      full   <= 1'b0;
    end
  end

  assign in_ready  = ENABLE ? !full : out_ready;
  assign out_valid = full || in_valid;
  assign out_op    = full ? op_q   : in_op;
  assign out_data  = full ? data_q : in_data;
  assign out_n     = full ? n_q    : in_n;

endmodule

// File: rtl/sterownik_rejestru_przesuwajacego.sv
// sterownik_rejestru_przesuwajacego
// Command sequencer for a 4-bit universal shift register (S1S0: 00 hold,
// 01 shift right, 10 shift left, 11 parallel load). One command per handshake;
// drives S1/S0/I for the needed cycles, captures Q and pulses done.
// Optional feature: define CMD_BUF_EN for a one-entry command buffer that lets
// a command be accepted while busy and start straight out of FIN.
//   clk, rst : clock, synchronous active-high reset
//   cmd      : command channel (slave modport): valid/ready, op, data, n
//   s0, s1   : mode lines to the shift register (registered)
//   i        : parallel data to the shift register, zero outside LOAD
//   q_in     : shift register Q feedback
//   busy     : command in progress (state != IDLE)
//   done     : one-cycle pulse in the FIN cycle
//   result   : q_in captured in the FIN cycle, held until the next FIN
module sterownik_rejestru_przesuwajacego
  import sterownik_rp_pkg::*;
  #(parameter int WIDTH = 4,
    parameter int CNT_W = 3)
  (
    input  logic                             clk,
    input  logic                             rst,
    sterownik_rejestru_przesuwajacego_if.slave cmd,
    output logic                             s0,
    output logic                             s1,
    output logic [WIDTH-1:0]                 i,
    input  logic [WIDTH-1:0]                 q_in,
    output logic                             busy,
    output logic                             done,
    output logic [WIDTH-1:0]                 result
  );

`ifdef CMD_BUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic             buf_valid;
  logic             buf_ready;
  op_t              buf_op;
  logic [WIDTH-1:0] buf_data;
  logic [CNT_W-1:0] buf_n;
  logic             take;

  stan_t            stan, stan_next;
  op_t              op_r, op_next;
  logic [WIDTH-1:0] data_r, data_next;
  logic [CNT_W-1:0] n_r, n_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       tryb;

  bufor_polecen #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ENABLE(BUF_EN)) u_bufor (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (cmd.cmd_valid),
    .in_ready  (cmd.cmd_ready),
    .in_op     (cmd.cmd_op),
    .in_data   (cmd.cmd_data),
    .in_n      (cmd.cmd_n),
    .out_valid (buf_valid),
    .out_ready (buf_ready),
    .out_op    (buf_op),
    .out_data  (buf_data),
    .out_n     (buf_n)
  );

  // FIN may chain straight into the next command only when buffering is on.
  assign buf_ready = (stan == IDLE) || (BUF_EN && (stan == FIN));
  assign take      = buf_valid && buf_ready;

  // Next-state and command-latch logic; a take overrides the FIN->IDLE default.
  always_comb begin
    stan_next = stan;
    op_next   = op_r;
    data_next = data_r;
    n_next    = n_r;
    cnt_next  = cnt;
    case (stan)
      IDLE:  stan_next = IDLE;
      LOAD: begin
        if (op_r == OP_LOAD_SHR && n_r != '0) begin
          stan_next = SHIFT;
          cnt_next  = n_r;
        end else begin
          stan_next = FIN;
        end
      end
      SHIFT: begin
        cnt_next = cnt - 1'b1;
        if (cnt == CNT_W'(1)) stan_next = FIN;
      end
      FIN:   stan_next = IDLE;
      default: stan_next = IDLE;
    endcase
    if (take) begin
      op_next   = buf_op;
      data_next = buf_data;
      n_next    = buf_n;
      cnt_next  = buf_n;
      if (buf_op == OP_LOAD || buf_op == OP_LOAD_SHR) stan_next = LOAD;
      else if (buf_n != '0)                           stan_next = SHIFT;
      else                                            stan_next = FIN;
    end
  end

  // State plus registered Moore outputs derived from the state being entered,
  // so the outputs line up with the state register without a decode stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      stan   <= IDLE;
      op_r   <= OP_LOAD;
      data_r <= '0;
      n_r    <= '0;
      cnt    <= '0;
      tryb   <= TRYB_WSTRZYMAJ;
      i      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      stan   <= stan_next;
      op_r   <= op_next;
      data_r <= data_next;
      n_r    <= n_next;
      cnt    <= cnt_next;
      tryb   <= tryb_stanu(stan_next, op_next);
      i      <= (stan_next == LOAD) ? data_next : '0;
      busy   <= (stan_next != IDLE);
      done   <= (stan_next == FIN);
      if (stan == FIN) result <= q_in;
    end
  end

  assign s1 = tryb[1];
  assign s0 = tryb[0];

endmodule

// File: tb/tb_sterownik_rejestru_przesuwajacego.sv
// tb_sterownik_rejestru_przesuwajacego
// Directed bench: the sequencer drives a behavioural 4-bit universal shift
// register (zero fill on shifts) whose Q feeds back into q_in.
// Build with or without CMD_BUF_EN; the back-to-back expectations follow it.
module tb_sterownik_rejestru_przesuwajacego;
  import sterownik_rp_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

`ifdef CMD_BUF_EN
  localparam int EXP_ACC2  = 1;
  localparam int EXP_LOAD2 = 3;
  localparam int EXP_DONE2 = 4;
`else
  localparam int EXP_ACC2  = 3;
  localparam int EXP_LOAD2 = 4;
  localparam int EXP_DONE2 = 5;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             s0, s1;
  logic [WIDTH-1:0] i;
  logic [WIDTH-1:0] q;
  logic             busy, done;
  logic [WIDTH-1:0] result;

  int vectors     = 0;
  int miscompares = 0;

  sterownik_rejestru_przesuwajacego_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cmd_if ();

  sterownik_rejestru_przesuwajacego #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .cmd    (cmd_if),
    .s0     (s0),
    .s1     (s1),
    .i      (i),
    .q_in   (q),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Behavioural universal shift register, zero fill on both shifts.
  always @(posedge clk) begin
    case ({s1, s0})
      2'b01:   q <= {1'b0, q[3:1]};
      2'b10:   q <= {q[2:0], 1'b0};
      2'b11:   q <= i;
      default: q <= q;
    endcase
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Issues one command and observes it up to its done pulse. Leaves the bench
  // #1 after the edge that follows the done cycle. lat = -1 on timeout.
  task automatic run_cmd(input op_t op, input logic [3:0] data, input logic [2:0] n,
                         output int lat, output int load_cyc, output int shr_cyc,
                         output int shl_cyc, output int bad_i, output logic [3:0] load_i);
    int k;
    lat = -1; load_cyc = 0; shr_cyc = 0; shl_cyc = 0; bad_i = 0; load_i = '0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = data;
    cmd_if.cmd_n     = n;
    k = 0;
    while (cmd_if.cmd_ready !== 1'b1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
    if (k < 50) begin
      for (int c = 1; c <= 40; c++) begin
        case ({s1, s0})
          2'b11: begin load_cyc++; load_i = i; end
          2'b01: shr_cyc++;
          2'b10: shl_cyc++;
          default: ;
        endcase
        if ({s1, s0} != 2'b11 && i !== 4'b0000) bad_i++;
        if (done === 1'b1) begin
          lat = c;
          break;
        end
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_LOAD;
    cmd_if.cmd_data  = '0;
    cmd_if.cmd_n     = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    vectors++; if ({s1, s0} !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_mode: got %b expected 00", {s1, s0}); end
    vectors++; if (i !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_i: got %b expected 0000", i); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (cmd_if.cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready: got %b expected 1", cmd_if.cmd_ready); end
    vectors++; if (result !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_result: got %b expected 0000", result); end
  endtask

  task automatic test_load();
    int lat, lc, rc, lfc, bi;
    logic [3:0] li;
    run_cmd(OP_LOAD, 4'b1010, 3'd0, lat, lc, rc, lfc, bi, li);
    vectors++; if (lat !== 2) begin miscompares++; $display("[TB] FAIL load_latency: got %0d expected 2", lat); end
    vectors++; if (lc !== 1 || li !== 4'b1010) begin miscompares++; $display("[TB] FAIL load_drive: got %0d cycles i=%b expected 1 cycle i=1010", lc, li); end
    vectors++; if (rc + lfc !== 0 || bi !== 0) begin miscompares++; $display("[TB] FAIL load_other: got shifts=%0d bad_i=%0d expected 0 0", rc + lfc, bi); end
    vectors++; if (result !== 4'b1010) begin miscompares++; $display("[TB] FAIL load_result: got %b expected 1010", result); end
    vectors++; if (q !== 4'b1010) begin miscompares++; $display("[TB] FAIL load_q: got %b expected 1010", q); end
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL load_after: got busy=%b done=%b expected 0 0", busy, done); end
  endtask

  task automatic test_shr();
    int lat, lc, rc, lfc, bi;
    logic [3:0] li;
    run_cmd(OP_SHR, 4'b0000, 3'd2, lat, lc, rc, lfc, bi, li);
    vectors++; if (lat !== 3) begin miscompares++; $display("[TB] FAIL shr_latency: got %0d expected 3", lat); end
    vectors++; if (rc !== 2 || lfc !== 0 || lc !== 0) begin miscompares++; $display("[TB] FAIL shr_cycles: got shr=%0d shl=%0d load=%0d expected 2 0 0", rc, lfc, lc); end
    vectors++; if (bi !== 0) begin miscompares++; $display("[TB] FAIL shr_i: got %0d nonzero-I cycles expected 0", bi); end
    vectors++; if (result !== 4'b0010) begin miscompares++; $display("[TB] FAIL shr_result: got %b expected 0010", result); end
  endtask

  task automatic test_load_shr_shl();
    int lat, lc, rc, lfc, bi;
    logic [3:0] li;
    run_cmd(OP_LOAD_SHR, 4'b1100, 3'd1, lat, lc, rc, lfc, bi, li);
    vectors++; if (lat !== 3) begin miscompares++; $display("[TB] FAIL ldshr_latency: got %0d expected 3", lat); end
    vectors++; if (lc !== 1 || li !== 4'b1100 || rc !== 1) begin miscompares++; $display("[TB] FAIL ldshr_cycles: got load=%0d i=%b shr=%0d expected 1 1100 1", lc, li, rc); end
    vectors++; if (result !== 4'b0110) begin miscompares++; $display("[TB] FAIL ldshr_result: got %b expected 0110", result); end

    run_cmd(OP_SHL, 4'b0000, 3'd0, lat, lc, rc, lfc, bi, li);
    vectors++; if (lat !== 1) begin miscompares++; $display("[TB] FAIL shl0_latency: got %0d expected 1", lat); end
    vectors++; if (lfc !== 0 || rc !== 0 || lc !== 0) begin miscompares++; $display("[TB] FAIL shl0_mode: got shl=%0d shr=%0d load=%0d expected 0 0 0", lfc, rc, lc); end
    vectors++; if (q !== 4'b0110 || result !== 4'b0110) begin miscompares++; $display("[TB] FAIL shl0_hold: got q=%b result=%b expected 0110 0110", q, result); end

    run_cmd(OP_SHL, 4'b0000, 3'd3, lat, lc, rc, lfc, bi, li);
    vectors++; if (lat !== 4) begin miscompares++; $display("[TB] FAIL shl3_latency: got %0d expected 4", lat); end
    vectors++; if (lfc !== 3 || rc !== 0) begin miscompares++; $display("[TB] FAIL shl3_cycles: got shl=%0d shr=%0d expected 3 0", lfc, rc); end
    vectors++; if (result !== 4'b0000) begin miscompares++; $display("[TB] FAIL shl3_result: got %b expected 0000", result); end
  endtask

  task automatic test_reset_abort();
    int k, pulses, lat, lc, rc, lfc, bi;
    logic [3:0] li;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_SHL;
    cmd_if.cmd_data  = 4'b0000;
    cmd_if.cmd_n     = 3'd3;
    k = 0;
    while (cmd_if.cmd_ready !== 1'b1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
    vectors++; if ({s1, s0} !== 2'b10) begin miscompares++; $display("[TB] FAIL abort_shift1: got %b expected 10", {s1, s0}); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++; if ({s1, s0} !== 2'b00 || i !== 4'b0000) begin miscompares++; $display("[TB] FAIL abort_mode: got s=%b i=%b expected 00 0000", {s1, s0}, i); end
    vectors++; if (busy !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_idle: got busy=%b ready=%b expected 0 1", busy, cmd_if.cmd_ready); end
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      if (done === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    vectors++; if (pulses !== 0) begin miscompares++; $display("[TB] FAIL abort_done: got %0d pulses expected 0", pulses); end
    run_cmd(OP_LOAD, 4'b0101, 3'd0, lat, lc, rc, lfc, bi, li);
    vectors++; if (lat !== 2 || result !== 4'b0101) begin miscompares++; $display("[TB] FAIL abort_reload: got lat=%0d result=%b expected 2 0101", lat, result); end
  endtask

  task automatic test_back_to_back();
    int k, nd, acc2, load2;
    int done_cyc[2];
    logic [3:0] res_mid;
    nd = 0; acc2 = -1; load2 = -1; done_cyc[0] = -1; done_cyc[1] = -1; res_mid = 'x;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_LOAD;
    cmd_if.cmd_data  = 4'b0011;
    cmd_if.cmd_n     = 3'd0;
    k = 0;
    while (cmd_if.cmd_ready !== 1'b1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    cmd_if.cmd_data = 4'b1001;
    for (int c = 1; c <= 20; c++) begin
      if (cmd_if.cmd_valid === 1'b1 && cmd_if.cmd_ready === 1'b1 && acc2 < 0) acc2 = c;
      if ({s1, s0} === 2'b11 && i === 4'b1001 && load2 < 0) load2 = c;
      if (done === 1'b1) begin
        if (nd < 2) done_cyc[nd] = c;
        nd++;
      end
      if (c == 3) res_mid = result;
      @(posedge clk); #1;
      if (acc2 == c) cmd_if.cmd_valid = 1'b0;
    end
    cmd_if.cmd_valid = 1'b0;
    vectors++; if (acc2 !== EXP_ACC2) begin miscompares++; $display("[TB] FAIL b2b_accept2: got cycle %0d expected %0d", acc2, EXP_ACC2); end
    vectors++; if (load2 !== EXP_LOAD2) begin miscompares++; $display("[TB] FAIL b2b_load2: got cycle %0d expected %0d", load2, EXP_LOAD2); end
    vectors++; if (nd !== 2 || done_cyc[0] !== 2 || done_cyc[1] !== EXP_DONE2) begin miscompares++; $display("[TB] FAIL b2b_done: got n=%0d at %0d,%0d expected 2 at 2,%0d", nd, done_cyc[0], done_cyc[1], EXP_DONE2); end
    vectors++; if (res_mid !== 4'b0011 || result !== 4'b1001) begin miscompares++; $display("[TB] FAIL b2b_result: got %b then %b expected 0011 then 1001", res_mid, result); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_shr();
    test_load_shr_shl();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
